seg7_scan_driver: RTL

//   Multiplexed N-digit BCD seven-segment display driver, registered outputs.
//   - Latches a packed BCD word on a load strobe.
//   - Time-multiplexes the digits onto one shared segment bus, one digit-enable per digit.
//   - Sits between the numeric datapath (counters, measurement blocks) and the board display pins.

---
 rtl/seg7_scan_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit BCD seven-segment scan driver with registered seg/digit_en outputs.
// Optional leading-zero suppression is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1000,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [6:0]        SEG_OFF  = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] EN_OFF   = {DIGITS{ACTIVE_LOW}};

   typedef enum logic {
      SCAN_WAIT = 1'b0,
      SCAN_RUN  = 1'b1
   } scan_state_t;

   logic [PRE_W-1:0]    prescaler;
   logic                tick;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_next;
   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] disp_word;
   logic [3:0]          digit_val;
   logic [DIGITS-1:0]   onehot;
   logic                blank;
   logic [6:0]          seg_next;
   scan_state_t         state;
   scan_state_t         state_next;
   logic                frame_pulse;

   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'b1111110;
         4'd1:    encode = 7'b0110000;
         4'd2:    encode = 7'b1101101;
         4'd3:    encode = 7'b1111001;
         4'd4:    encode = 7'b0110011;
         4'd5:    encode = 7'b1011011;
         4'd6:    encode = 7'b1011111;
         4'd7:    encode = 7'b1110000;
         4'd8:    encode = 7'b1111111;
         4'd9:    encode = 7'b1111011;
         default: encode = 7'b0000000;
      endcase
   endfunction

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   assign tick     = (prescaler == PRE_LAST);
   assign idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

   // A load coinciding with a tick feeds bcd_in straight through, so no stale digit is shown.
   assign disp_word = load ? bcd_in : shadow;

   // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latch).
   always_comb begin
      digit_val = disp_word[3:0];
      onehot    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_next == IDX_W'(k)) begin
            digit_val = disp_word[4*k +: 4];
            onehot[k] = 1'b1;
         end
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   logic [DIGITS-1:0] lz_mask;

   // Walk down from the top digit; a digit is blanked while everything above it is zero.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run   = zero_run & (disp_word[4*k +: 4] == 4'd0);
         lz_mask[k] = zero_run;
      end
   end

   assign blank = |(lz_mask & onehot);
`else
   assign blank = 1'b0;
`endif

   assign seg_next = blank ? 7'b0000000 : encode(digit_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SCAN_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // The first tick after reset only arms frame reporting; later wraps pulse frame_done.
   always_comb begin
      state_next  = state;
      frame_pulse = 1'b0;
      case (state)
         SCAN_WAIT: begin
            if (tick) begin
               state_next = SCAN_RUN;
            end
         end
         SCAN_RUN: begin
            frame_pulse = tick && (idx == IDX_LAST);
         end
         default: begin
            state_next = SCAN_WAIT;
         end
      endcase
   end

   // NOTE: shadow is an ordinary register bank, so it takes the reset and reads as zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= IDX_LAST;
         shadow     <= '0;
         seg        <= SEG_OFF;
         digit_en   <= EN_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_pulse;
         if (load) begin
            shadow <= bcd_in;
         end
         if (tick) begin
            idx      <= idx_next;
            seg      <= seg_next ^ SEG_OFF;
            digit_en <= onehot ^ EN_OFF;
         end
      end
   end

endmodule
